// File: rtl/difftest_step_batcher_if.sv
// Commit-count input bundle and step/status outputs of difftest_step_batcher.
// master = testbench/driver side, slave = batcher side.
interface difftest_step_batcher_if #(
  parameter int STEPWIDTH = 8,
  parameter int IN_WIDTH  = 4
);
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_count;
  logic                 flush_req;
  logic [7:0]           simv_result;
  logic [STEPWIDTH-1:0] step;
  logic                 halted;
  logic [STEPWIDTH-1:0] pending;
  logic [31:0]          dropped;

  modport master (
    output in_valid, in_count, flush_req, simv_result,
    input  step, halted, pending, dropped
  );

  modport slave (
    input  in_valid, in_count, flush_req, simv_result,
    output step, halted, pending, dropped
  );
endinterface

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into single-cycle step pulses; stops once the host reports a result.
// Optional idle-timeout flush is enabled by defining DIFFTEST_STEP_TIMEOUT_EN.
module difftest_step_batcher #(
  parameter int STEPWIDTH = 8,
  parameter int IN_WIDTH  = 4,
  parameter int THRESHOLD = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  difftest_step_batcher_if.slave   bus
);
  localparam int SW = STEPWIDTH;
  localparam logic [SW:0] MAXV = {1'b0, {SW{1'b1}}};
  localparam logic [SW:0] THR  = (SW+1)'(THRESHOLD);

  typedef enum logic {RUN, HALT} state_t;

  state_t         state_reg, state_next;
  logic [SW-1:0]  acc_reg, acc_next;
  logic [SW-1:0]  step_reg, step_next;
  logic [31:0]    dropped_reg, dropped_next;

  logic [SW:0]    inc, sum;
  logic [32:0]    dropped_sum;
  logic           overflow, stop_seen, timeout_hit;

  assign inc         = bus.in_valid ? (SW+1)'(bus.in_count) : '0;
  assign sum         = {1'b0, acc_reg} + inc;
  assign overflow    = sum > MAXV;
  assign stop_seen   = bus.simv_result != 8'd0;
  assign dropped_sum = {1'b0, dropped_reg} + 33'(inc);

`ifdef DIFFTEST_STEP_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT) + 1;
  logic [IW-1:0] idle_reg, idle_next;
  assign timeout_hit = (idle_reg == IW'(TIMEOUT - 1)) && (acc_reg != '0);
`else
  // Without the idle counter a partial batch only leaves via threshold, flush_req or overflow.
  assign timeout_hit = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= RUN;
      acc_reg     <= '0;
      step_reg    <= '0;
      dropped_reg <= '0;
`ifdef DIFFTEST_STEP_TIMEOUT_EN
      idle_reg    <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      step_reg    <= step_next;
      dropped_reg <= dropped_next;
`ifdef DIFFTEST_STEP_TIMEOUT_EN
      idle_reg    <= idle_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    step_next    = '0;
    dropped_next = dropped_reg;
`ifdef DIFFTEST_STEP_TIMEOUT_EN
    idle_next    = '0;
`endif
    case (state_reg)
      RUN: begin
        if (stop_seen) begin
          // Halt-entry: no pulse, keep this cycle's work in acc (saturated).
          state_next = HALT;
          acc_next   = overflow ? MAXV[SW-1:0] : sum[SW-1:0];
        end else if (overflow) begin
          step_next = acc_reg;
          acc_next  = inc[SW-1:0];
        end else if (sum >= THR || ((bus.flush_req || timeout_hit) && sum != '0)) begin
          step_next = sum[SW-1:0];
          acc_next  = '0;
        end else begin
          acc_next = sum[SW-1:0];
`ifdef DIFFTEST_STEP_TIMEOUT_EN
          idle_next = (acc_reg != '0) ? idle_reg + 1'b1 : '0;
`endif
        end
      end
      default: begin
        dropped_next = dropped_sum[32] ? 32'hFFFF_FFFF : dropped_sum[31:0];
      end
    endcase
  end

  always_comb begin
    bus.step    = step_reg;
    bus.halted  = (state_reg == HALT);
    bus.pending = acc_reg;
    bus.dropped = dropped_reg;
  end
endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed bench for difftest_step_batcher: three instances (THRESHOLD 64/255/25) share one stimulus stream.
module tb_difftest_step_batcher;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_count = 4'd0;
  logic       flush_req = 1'b0;
  logic [7:0] simv_result = 8'd0;
  int         total = 0;
  int         bad = 0;

  always #5 clock = ~clock;

  difftest_step_batcher_if #(.STEPWIDTH(8), .IN_WIDTH(4)) if_a ();
  difftest_step_batcher_if #(.STEPWIDTH(8), .IN_WIDTH(4)) if_b ();
  difftest_step_batcher_if #(.STEPWIDTH(8), .IN_WIDTH(4)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.in_count = in_count;
  assign if_a.flush_req = flush_req; assign if_a.simv_result = simv_result;
  assign if_b.in_valid = in_valid;  assign if_b.in_count = in_count;
  assign if_b.flush_req = flush_req; assign if_b.simv_result = simv_result;
  assign if_c.in_valid = in_valid;  assign if_c.in_count = in_count;
  assign if_c.flush_req = flush_req; assign if_c.simv_result = simv_result;

  difftest_step_batcher #(.STEPWIDTH(8), .IN_WIDTH(4), .THRESHOLD(64), .TIMEOUT(1024))
    u_a (.clock(clock), .reset(reset), .bus(if_a));
  difftest_step_batcher #(.STEPWIDTH(8), .IN_WIDTH(4), .THRESHOLD(255), .TIMEOUT(1024))
    u_b (.clock(clock), .reset(reset), .bus(if_b));
  difftest_step_batcher #(.STEPWIDTH(8), .IN_WIDTH(4), .THRESHOLD(25), .TIMEOUT(8))
    u_c (.clock(clock), .reset(reset), .bus(if_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("check %-14s obs=%0d exp=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge; return after the next falling edge so outputs reflect one posedge.
  task automatic cyc(input logic v, input logic [3:0] c, input logic f, input logic [7:0] s);
    in_valid = v; in_count = c; flush_req = f; simv_result = s;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 4'd0, 1'b0, 8'd0);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_step", 32'(if_a.step), 0);
    chk("rst_halted", 32'(if_a.halted), 0);
    chk("rst_pending", 32'(if_a.pending), 0);
    chk("rst_dropped", if_a.dropped, 0);

    // Threshold: 16 x 4 -> one pulse of 64
    for (int i = 0; i < 15; i++) cyc(1'b1, 4'd4, 1'b0, 8'd0);
    chk("thr_pre_step", 32'(if_a.step), 0);
    chk("thr_pre_pend", 32'(if_a.pending), 60);
    cyc(1'b1, 4'd4, 1'b0, 8'd0);
    chk("thr_step", 32'(if_a.step), 64);
    chk("thr_pend", 32'(if_a.pending), 0);
    cyc(1'b0, 4'd0, 1'b0, 8'd0);
    chk("thr_after", 32'(if_a.step), 0);

    // flush_req with this cycle's input; empty flush gives no pulse
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'd3, 1'b0, 8'd0);
    chk("fl_pend", 32'(if_a.pending), 15);
    cyc(1'b1, 4'd2, 1'b1, 8'd0);
    chk("fl_step", 32'(if_a.step), 17);
    chk("fl_pend0", 32'(if_a.pending), 0);
    cyc(1'b1, 4'd0, 1'b1, 8'd0);
    chk("fl_empty", 32'(if_a.step), 0);
    chk("fl_empty_pend", 32'(if_a.pending), 0);

    // Overflow beats flush_req on the same cycle (THRESHOLD=255 instance)
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'd15, 1'b0, 8'd0);
    cyc(1'b1, 4'd10, 1'b0, 8'd0);
    chk("ov_pend250", 32'(if_b.pending), 250);
    chk("ov_pre_step", 32'(if_b.step), 0);
    cyc(1'b1, 4'd10, 1'b1, 8'd0);
    chk("ov_step", 32'(if_b.step), 250);
    chk("ov_pend", 32'(if_b.pending), 10);
    cyc(1'b0, 4'd0, 1'b1, 8'd0);
    chk("ov_flush_rem", 32'(if_b.step), 10);
    chk("ov_pend0", 32'(if_b.pending), 0);

    // Halt entry would cross THRESHOLD=25: no pulse, acc keeps 25, later work is dropped
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b0, 8'd0);
    chk("h_pend20", 32'(if_c.pending), 20);
    cyc(1'b1, 4'd5, 1'b0, 8'h01);
    chk("h_step", 32'(if_c.step), 0);
    chk("h_halted", 32'(if_c.halted), 1);
    chk("h_pend", 32'(if_c.pending), 25);
    chk("h_drop0", if_c.dropped, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'd2, 1'b0, 8'd0);
      chk("h_step_hold", 32'(if_c.step), 0);
    end
    chk("h_dropped", if_c.dropped, 20);
    chk("h_pend_frz", 32'(if_c.pending), 25);
    chk("h_sticky", 32'(if_c.halted), 1);

    // Halt entry saturates acc at 255
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'd15, 1'b0, 8'd0);
    cyc(1'b1, 4'd12, 1'b0, 8'd0);
    chk("sat_pre", 32'(if_b.pending), 252);
    cyc(1'b1, 4'd15, 1'b0, 8'h80);
    chk("sat_pend", 32'(if_b.pending), 255);
    chk("sat_step", 32'(if_b.step), 0);
    chk("sat_halted", 32'(if_b.halted), 1);

    // Mid-batch reset discards the accumulator without a pulse
    do_reset();
    cyc(1'b1, 4'd15, 1'b0, 8'd0);
    cyc(1'b1, 4'd15, 1'b0, 8'd0);
    chk("mr_pend30", 32'(if_a.pending), 30);
    reset = 1'b0;
    cyc(1'b1, 4'd15, 1'b0, 8'd0);
    chk("mr_step", 32'(if_a.step), 0);
    chk("mr_pend", 32'(if_a.pending), 0);
    chk("mr_halted", 32'(if_a.halted), 0);
    chk("mr_dropped", if_a.dropped, 0);
    reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, 8'd0);
    chk("mr_after", 32'(if_a.step), 0);

    // Idle partial batch (TIMEOUT=8 instance)
    do_reset();
    cyc(1'b1, 4'd5, 1'b0, 8'd0);
    chk("to_pend5", 32'(if_c.pending), 5);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 4'd0, 1'b0, 8'd0);
`ifdef DIFFTEST_STEP_TIMEOUT_EN
      chk("to_step", 32'(if_c.step), (i == 8) ? 32'd5 : 32'd0);
      chk("to_pend", 32'(if_c.pending), (i >= 8) ? 32'd0 : 32'd5);
`else
      chk("to_step", 32'(if_c.step), 0);
      chk("to_pend", 32'(if_c.pending), 5);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
